// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, default sizes and stage-control bundle
package pipe_ctrl_pkg;

    localparam int DEF_CNT_W   = 32;
    localparam int DEF_TIMEOUT = 255;

    localparam logic [0:0] S_RUN      = 1'b0;
    localparam logic [0:0] S_MEM_WAIT = 1'b1;

    typedef enum logic [0:0] {
        RUN      = S_RUN,
        MEM_WAIT = S_MEM_WAIT
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_write;
    } stage_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// perf_counter: wrapping event counter with synchronous clear
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline with
// memory-wait watchdog and stall/flush performance counters
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             hazard_i,
    input  logic             branch_taken_i,
    input  logic             mem_access_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_write_o,
    output logic             mem_req_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          active;
    logic          freeze;
    logic          go;
    stage_ctrl_t   ctrl;

    // rst_i is folded in so an asserted reset drops the request without a clock
    assign active    = rst_i & start_i;
    assign mem_req_o = active & ((state == MEM_WAIT) | mem_access_i);
    assign freeze    = mem_req_o & ~mem_ack_i;
    assign go        = active & ~freeze;

    assign ctrl = '{
        pc_write:     go & ~hazard_i,
        if_id_write:  go & ~hazard_i,
        if_id_flush:  go & ~hazard_i & branch_taken_i,
        id_ex_bubble: go & hazard_i,
        ex_mem_write: go,
        mem_wb_write: go
    };

    assign pc_write_o     = ctrl.pc_write;
    assign if_id_write_o  = ctrl.if_id_write;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign id_ex_bubble_o = ctrl.id_ex_bubble;
    assign ex_mem_write_o = ctrl.ex_mem_write;
    assign mem_wb_write_o = ctrl.mem_wb_write;

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_o <= 1'b0;
        end else if (!start_i) begin
            state <= RUN;
        end else if (state == RUN) begin
            if (mem_access_i && !mem_ack_i) begin
                state    <= MEM_WAIT;
                wait_cnt <= '0;
            end
        end else begin
            if (mem_ack_i)
                state <= RUN;
            if (wait_cnt != WW'(TIMEOUT))
                wait_cnt <= wait_cnt + 1'b1;
            // error rises on the same edge that wait_cnt reaches TIMEOUT
            if (wait_cnt == WW'(TIMEOUT - 1))
                mem_err_o <= 1'b1;
        end

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (active & ~ctrl.pc_write),
        .clear (1'b0),
        .cnt   (stall_cnt_o)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (ctrl.if_id_flush),
        .clear (1'b0),
        .cnt   (flush_cnt_o)
    );

endmodule
